// File: rtl/conv_mem_pkg.sv
// Shared constants and FSM encoding for the layer-memory arbiter.
// The LOCKED state only exists when LMA_LOCK_EN is defined.
package conv_mem_pkg;

    localparam logic [2:0] CSEL_NONE  = 3'd0;
    localparam logic [2:0] CSEL_L0_K0 = 3'd1;
    localparam logic [2:0] CSEL_L1_K0 = 3'd3;

    localparam int LMA_AW = 12;
    localparam int LMA_DW = 20;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE
`ifdef LMA_LOCK_EN
        , LOCKED
`endif
    } arb_state_e;

endpackage

// File: rtl/layer_mem_arbiter_if.sv
// Requester command bus plus the shared layer-memory port.
// The arbiter uses the slave view; requesters and memory use the master view.
interface layer_mem_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = conv_mem_pkg::LMA_AW,
    parameter int DW   = conv_mem_pkg::LMA_DW,
    parameter int SW   = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*SW-1:0] sel;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               cwr;
    logic               crd;
    logic [SW-1:0]      csel;
    logic [AW-1:0]      caddr_wr;
    logic [DW-1:0]      cdata_wr;
    logic [AW-1:0]      caddr_rd;
    logic [DW-1:0]      cdata_rd;

    modport slave (
        input  req, we, sel, addr, wdata, lock, cdata_rd,
        output gnt, rvalid, rdata, cwr, crd, csel, caddr_wr, cdata_wr, caddr_rd
    );

    modport master (
        output req, we, sel, addr, wdata, lock, cdata_rd,
        input  gnt, rvalid, rdata, cwr, crd, csel, caddr_wr, cdata_wr, caddr_rd
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester after ptr_i, with wraparound.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] winner_o,
    output logic            valid_o
);
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!valid_o && eligible_i[j] && (j == (int'(ptr_i) + k) % NREQ)) begin
                    winner_o[j] = 1'b1;
                    valid_o     = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter sharing the layer-memory port among NREQ requesters.
// Define LMA_LOCK_EN to let a requester keep ownership across commands via lock.
module layer_mem_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = conv_mem_pkg::LMA_AW,
    parameter int DW   = conv_mem_pkg::LMA_DW,
    parameter int SW   = 3
) (
    input logic                clk,
    input logic                reset,
    layer_mem_arbiter_if.slave bus
);
    import conv_mem_pkg::*;

    localparam int PW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, rtag_q, elig, win_oh;
    logic            win_vld, cmd_on, we_q, we_d, crd_w;
    logic [SW-1:0]   csel_q, csel_d;
    logic [AW-1:0]   caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
    logic [DW-1:0]   cdata_wr_q, cdata_wr_d, rdata_q;

`ifdef LMA_LOCK_EN
    logic [NREQ-1:0] own_oh;
    logic            lock_hold, win_lock;

    // The pointer parks on the owner while locked, so it doubles as the owner id.
    always_comb begin
        own_oh = '0;
        for (int j = 0; j < NREQ; j++) own_oh[j] = (ptr_q == PW'(j));
    end
    assign lock_hold = |(own_oh & bus.req & bus.lock);
    assign win_lock  = |(win_oh & bus.lock);
`else
    logic unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .eligible_i (elig),
        .ptr_i      (ptr_q),
        .winner_o   (win_oh),
        .valid_o    (win_vld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = win_vld ? ISSUE : IDLE;
`ifdef LMA_LOCK_EN
        if (state_q == LOCKED && lock_hold) state_d = LOCKED;
        else if (win_vld && win_lock)       state_d = LOCKED;
`endif
    end

    // A requester granted last cycle is masked, giving the 1-command-per-2-cycles limit.
    always_comb begin
        elig   = bus.req & ~gnt_q;
        cmd_on = 1'b0;
        case (state_q)
            ISSUE: cmd_on = 1'b1;
`ifdef LMA_LOCK_EN
            LOCKED: begin
                cmd_on = |gnt_q;
                if (lock_hold) elig = own_oh & bus.req & ~gnt_q;
            end
`endif
            default: cmd_on = 1'b0;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        we_d       = we_q;
        csel_d     = csel_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        caddr_rd_d = caddr_rd_q;
        for (int j = 0; j < NREQ; j++) begin
            if (win_oh[j]) begin
                ptr_d  = PW'(j);
                we_d   = bus.we[j];
                csel_d = bus.sel[j*SW +: SW];
                if (bus.we[j]) begin
                    caddr_wr_d = bus.addr[j*AW +: AW];
                    cdata_wr_d = bus.wdata[j*DW +: DW];
                end else begin
                    caddr_rd_d = bus.addr[j*AW +: AW];
                end
            end
        end
    end

    // Command stage: winner registered onto the memory bus; read-tag stage one cycle behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q      <= '0;
            ptr_q      <= PW'(NREQ - 1);
            we_q       <= 1'b0;
            csel_q     <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            caddr_rd_q <= '0;
            rtag_q     <= '0;
            rdata_q    <= '0;
        end else begin
            gnt_q      <= win_oh;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            csel_q     <= csel_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            caddr_rd_q <= caddr_rd_d;
            rtag_q     <= crd_w ? gnt_q : '0;
            if (crd_w) rdata_q <= bus.cdata_rd;
        end
    end

    assign crd_w        = cmd_on & ~we_q;
    assign bus.gnt      = gnt_q;
    assign bus.cwr      = cmd_on & we_q;
    assign bus.crd      = crd_w;
    assign bus.csel     = cmd_on ? csel_q : SW'(CSEL_NONE);
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.cdata_wr = cdata_wr_q;
    assign bus.caddr_rd = caddr_rd_q;
    assign bus.rvalid   = rtag_q;
    assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Randomized bench for layer_mem_arbiter against a cycle-level round-robin reference model.
// The lock-ownership scenario runs only when LMA_LOCK_EN is defined.
module tb_layer_mem_arbiter;
    import conv_mem_pkg::*;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 20;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    layer_mem_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW), .SW(SW)) bus ();

    layer_mem_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign bus.cdata_rd = bus.crd ? mem[bus.caddr_rd] : '0;

    logic          t_req   [N];
    logic          t_we    [N];
    logic [SW-1:0] t_sel   [N];
    logic [AW-1:0] t_addr  [N];
    logic [DW-1:0] t_wdata [N];
    logic [N-1:0]  t_lock;

    int            m_ptr, m_gnt, m_rd;
    logic [N-1:0]  e_gnt, e_rvalid;
    logic          e_cwr, e_crd;
    logic [SW-1:0] e_csel;
    logic [AW-1:0] e_caddr_wr, e_caddr_rd;
    logic [DW-1:0] e_cdata_wr, e_rdata;

    int checks   = 0;
    int failures = 0;
`ifdef LMA_LOCK_EN
    int n_own, n_other;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [N-1:0]    r, w;
        logic [N*SW-1:0] s;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        for (int i = 0; i < N; i++) begin
            r[i]            = t_req[i];
            w[i]            = t_we[i];
            s[i*SW +: SW]   = t_sel[i];
            a[i*AW +: AW]   = t_addr[i];
            d[i*DW +: DW]   = t_wdata[i];
        end
        bus.req   = r;
        bus.we    = w;
        bus.sel   = s;
        bus.addr  = a;
        bus.wdata = d;
        bus.lock  = t_lock;
    endtask

    task automatic rand_cmd(input int i);
        t_we[i]    = 1'($urandom_range(0, 1));
        t_sel[i]   = SW'($urandom_range(0, 7));
        t_addr[i]  = AW'($urandom_range(0, (1<<AW)-1));
        t_wdata[i] = DW'($urandom);
    endtask

    task automatic model_reset();
        m_ptr = N - 1;  m_gnt = -1;  m_rd = -1;
        e_gnt = '0;  e_rvalid = '0;  e_cwr = 1'b0;  e_crd = 1'b0;  e_csel = '0;
        e_caddr_wr = '0;  e_caddr_rd = '0;  e_cdata_wr = '0;  e_rdata = '0;
    endtask

    // Next-cycle outputs from the inputs that the coming clock edge will sample.
    task automatic predict();
        int w;
        w = -1;
        e_rvalid = '0;
        if (m_rd >= 0) begin
            e_rvalid[m_rd] = 1'b1;
            e_rdata        = mem[e_caddr_rd];
        end
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (w < 0 && t_req[i] && i != m_gnt) w = i;
        end
        e_gnt = '0;  e_cwr = 1'b0;  e_crd = 1'b0;  e_csel = '0;
        if (w >= 0) begin
            e_gnt[w] = 1'b1;
            e_csel   = t_sel[w];
            if (t_we[w]) begin
                e_cwr = 1'b1;  e_caddr_wr = t_addr[w];  e_cdata_wr = t_wdata[w];
            end else begin
                e_crd = 1'b1;  e_caddr_rd = t_addr[w];
            end
            m_ptr = w;
        end
        m_gnt = w;
        m_rd  = (w >= 0 && !t_we[w]) ? w : -1;
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, "_gnt"},      32'(bus.gnt),      32'(e_gnt));
        chk({ph, "_rvalid"},   32'(bus.rvalid),   32'(e_rvalid));
        chk({ph, "_cwr"},      32'(bus.cwr),      32'(e_cwr));
        chk({ph, "_crd"},      32'(bus.crd),      32'(e_crd));
        chk({ph, "_csel"},     32'(bus.csel),     32'(e_csel));
        chk({ph, "_caddr_wr"}, 32'(bus.caddr_wr), 32'(e_caddr_wr));
        chk({ph, "_cdata_wr"}, 32'(bus.cdata_wr), 32'(e_cdata_wr));
        chk({ph, "_caddr_rd"}, 32'(bus.caddr_rd), 32'(e_caddr_rd));
        if (e_rvalid != '0) chk({ph, "_rdata"}, 32'(bus.rdata), 32'(e_rdata));
    endtask

    task automatic cycle(input string ph);
        drive();
        predict();
        @(posedge clk);
        #1;
        check_outputs(ph);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            t_req[i] = 1'b0;
            rand_cmd(i);
        end
        t_lock = '0;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = DW'($urandom);
        clear_reqs();
        drive();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("rst");
        chk("rst_rdata", 32'(bus.rdata), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single write from requester 0 right after reset
        t_req[0] = 1'b1;  t_we[0] = 1'b1;  t_addr[0] = 12'h005;
        t_wdata[0] = 20'h0ABCD;  t_sel[0] = CSEL_L0_K0;
        cycle("t1");
        chk("t1_gnt_const",   32'(bus.gnt),      32'h1);
        chk("t1_cwr_const",   32'(bus.cwr),      32'h1);
        chk("t1_caddr_const", 32'(bus.caddr_wr), 32'h005);
        chk("t1_cdata_const", 32'(bus.cdata_wr), 32'h0ABCD);
        chk("t1_csel_const",  32'(bus.csel),     32'h1);
        t_req[0] = 1'b0;
        cycle("t1_idle");

        // Single read from requester 1 with a known memory word
        mem[12'h010] = 20'h12345;
        t_req[1] = 1'b1;  t_we[1] = 1'b0;  t_addr[1] = 12'h010;  t_sel[1] = CSEL_L1_K0;
        cycle("t2");
        chk("t2_crd_const",   32'(bus.crd),      32'h1);
        chk("t2_caddr_const", 32'(bus.caddr_rd), 32'h010);
        t_req[1] = 1'b0;
        cycle("t2_ret");
        chk("t2_rvalid_const", 32'(bus.rvalid), 32'h2);
        chk("t2_rdata_const",  32'(bus.rdata),  32'h12345);

        // All requesters held: full bus rate rotation
        for (int i = 0; i < N; i++) begin
            t_req[i] = 1'b1;
            rand_cmd(i);
        end
        for (int c = 0; c < 12; c++) begin
            cycle("t3");
            chk("t3_busy", 32'(|bus.gnt), 32'h1);
            for (int i = 0; i < N; i++) if (e_gnt[i]) rand_cmd(i);
        end

        // Only requester 2 held: grant every other cycle
        clear_reqs();
        t_req[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cycle("t4");
            if (e_gnt[2]) rand_cmd(2);
        end

        // Reset during the read-strobe cycle
        clear_reqs();
        cycle("t5_pre");
        t_req[2] = 1'b1;  t_we[2] = 1'b0;
        cycle("t5");
        chk("t5_crd_const", 32'(bus.crd), 32'h1);
        t_req[2] = 1'b0;
        drive();
        reset = 1'b1;
        #1;
        chk("t5_gnt0",   32'(bus.gnt),      32'h0);
        chk("t5_crd0",   32'(bus.crd),      32'h0);
        chk("t5_cwr0",   32'(bus.cwr),      32'h0);
        chk("t5_csel0",  32'(bus.csel),     32'h0);
        chk("t5_addr0",  32'(bus.caddr_rd), 32'h0);
        chk("t5_waddr0", 32'(bus.caddr_wr), 32'h0);
        chk("t5_wdata0", 32'(bus.cdata_wr), 32'h0);
        chk("t5_rdata0", 32'(bus.rdata),    32'h0);
        @(posedge clk);
        #1;
        chk("t5_no_rvalid", 32'(bus.rvalid), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            t_req[i] = 1'b1;
            rand_cmd(i);
        end
        cycle("t5_after");
        chk("t5_first_gnt", 32'(bus.gnt), 32'h1);

        // Random traffic; requesters only change a command after it has been granted
        for (int c = 0; c < 500; c++) begin
`ifndef LMA_LOCK_EN
            t_lock = N'($urandom);
`endif
            cycle("rnd");
            for (int i = 0; i < N; i++) begin
                if (t_req[i] && e_gnt[i]) begin
                    t_req[i] = ($urandom_range(0, 3) != 0);
                    rand_cmd(i);
                end else if (!t_req[i] && $urandom_range(0, 2) == 0) begin
                    t_req[i] = 1'b1;
                    rand_cmd(i);
                end
            end
        end

`ifdef LMA_LOCK_EN
        // Requester 1 locks the bus while 0 and 2 wait
        clear_reqs();
        drive();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        t_req[1] = 1'b1;  t_lock = 3'b010;
        drive();
        @(posedge clk);
        #1;
        chk("t6_own", 32'(bus.gnt), 32'h2);
        t_req[0] = 1'b1;  t_req[2] = 1'b1;
        drive();
        n_own = 0;  n_other = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            if (bus.gnt == 3'b010) n_own++;
            if ((bus.gnt & 3'b101) != 3'b000) n_other++;
        end
        chk("t6_n_own",   32'(n_own),   32'd3);
        chk("t6_n_other", 32'(n_other), 32'd0);
        t_req[1] = 1'b0;  t_lock = '0;
        drive();
        @(posedge clk);
        #1;
        chk("t6_after_unlock", 32'(bus.gnt), 32'h4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
